// File: rtl/tff_seq_ctrl_pkg.sv
// Shared types and the modulo step function for the TFF-bank sequencer.
package tff_seq_pkg;

   localparam int MAX_W = 16;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   typedef logic [MAX_W-1:0] cnt_t;
   typedef logic [MAX_W:0]   mod_t;

   typedef struct packed {
      cnt_t nxt;
      logic wrap;
   } step_t;

   // m is the effective modulus (1..2^MAX_W); out-of-range counts wrap on the next step.
   function automatic step_t next_count(input cnt_t q, input logic up, input mod_t m);
      step_t r;
      mod_t  qe;
      qe     = mod_t'(q);
      r.nxt  = q;
      r.wrap = 1'b0;
      if (up) begin
         if (qe >= m - mod_t'(1)) begin
            r.nxt  = '0;
            r.wrap = 1'b1;
         end else begin
            r.nxt = q + cnt_t'(1);
         end
      end else begin
         if (q == '0 || qe >= m) begin
            r.nxt  = cnt_t'(m - mod_t'(1));
            r.wrap = 1'b1;
         end else begin
            r.nxt = q - cnt_t'(1);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/tff_seq_ctrl_if.sv
// Host-side command/status bundle of the TFF sequencer.
// Optional TFF_SEQ_QBAR_CHK_EN adds the sticky err status.
interface tff_seq_if #(parameter int WIDTH = 4);

   logic             start;
   logic             abort;
   logic             dir;
   logic [WIDTH-1:0] modulus;
   logic [WIDTH-1:0] run_len;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qbar;
   logic [WIDTH-1:0] t_out;
   logic             busy;
   logic             done;
   logic             tc;
`ifdef TFF_SEQ_QBAR_CHK_EN
   logic             err;
`endif

   modport master (
      output start, abort, dir, modulus, run_len, load, load_val,
      input  q, qbar, t_out, busy, done, tc
`ifdef TFF_SEQ_QBAR_CHK_EN
      , input err
`endif
   );

   modport slave (
      input  start, abort, dir, modulus, run_len, load, load_val,
      output q, qbar, t_out, busy, done, tc
`ifdef TFF_SEQ_QBAR_CHK_EN
      , output err
`endif
   );

endinterface

// File: rtl/tff_seq_ctrl_bank.sv
// WIDTH-bit bank of T flip-flops: each bit toggles on a clock edge where its t bit is set.
module tff_bank #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb q_d = q_q ^ t;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q_q <= '0;
      else     q_q <= q_d;
   end

   assign q    = q_q;
   assign qbar = ~q_q;

endmodule

// File: rtl/tff_seq_ctrl.sv
// Modulo up/down counter sequencer driving a TFF bank via per-bit toggle enables.
// Optional TFF_SEQ_QBAR_CHK_EN adds a sticky qbar/q consistency checker (err).
module tff_seq_ctrl
   import tff_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input logic     clk,
   input logic     rst,
   tff_seq_if.slave bus
);

   state_e           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             tc_q, tc_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] len_q, len_d;

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qbar;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] t;
   mod_t             m_eff;
   step_t            step;

   always_comb begin
      m_eff = (bus.modulus == '0) ? (mod_t'(1) << WIDTH) : mod_t'(bus.modulus);
      step  = next_count(cnt_t'(q), bus.dir, m_eff);
   end

   if (WIDTH < MAX_W) begin : g_pad
      logic unused_hi;
      assign unused_hi = |step.nxt[MAX_W-1:WIDTH];
   end

   always_comb begin
      state_d = state_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      tc_d    = 1'b0;
      cnt_d   = cnt_q;
      len_d   = len_q;
      nxt     = q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               busy_d  = 1'b1;
               cnt_d   = '0;
               len_d   = bus.run_len;
            end
         end
         RUN: begin
            busy_d = 1'b1;
            if (bus.abort) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               // A load replaces this step's value but still consumes a step.
               nxt   = step.nxt[WIDTH-1:0];
               tc_d  = step.wrap & ~bus.load;
               cnt_d = cnt_q + 1'b1;
               if (len_q != '0 && cnt_d == len_q) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.load) nxt = bus.load_val;
      t = q ^ nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tc_q    <= 1'b0;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         tc_q    <= tc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

   tff_bank #(.WIDTH(WIDTH)) u_bank (
      .clk  (clk),
      .rst  (rst),
      .t    (t),
      .q    (q),
      .qbar (qbar)
   );

   assign bus.q     = q;
   assign bus.qbar  = qbar;
   assign bus.t_out = t;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.tc    = tc_q;

`ifdef TFF_SEQ_QBAR_CHK_EN
   logic err_q, err_d;

   // Watches the bundle outputs so any corruption on the way out is caught.
   always_comb err_d = err_q | (bus.qbar != ~bus.q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Randomized and directed bench for tff_seq_ctrl against a cycle-level behavioural model.
module tb_tff_seq_ctrl;

   localparam int W    = 4;
   localparam int MASK = (1 << W) - 1;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   tff_seq_if #(.WIDTH(W)) bif ();

   tff_seq_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: count value, run activity, steps taken, requested length.
   int mq      = 0;
   bit m_run   = 0;
   bit m_cool  = 0;
   int m_steps = 0;
   int m_len   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      mq      = 0;
      m_run   = 0;
      m_cool  = 0;
      m_steps = 0;
      m_len   = 0;
   endtask

   // Called at a falling edge; drives one cycle of inputs and checks both sides of the rising edge.
   task automatic cyc(input bit st, input bit ab, input bit dr, input bit ld,
                      input int md, input int rl, input int lv);
      int m, nxt;
      bit wrap, acc, ended;
      bif.start    = st;
      bif.abort    = ab;
      bif.dir      = dr;
      bif.load     = ld;
      bif.modulus  = W'(md);
      bif.run_len  = W'(rl);
      bif.load_val = W'(lv);
      m    = (md == 0) ? (1 << W) : md;
      nxt  = mq;
      wrap = 0;
      if (m_run && !ab) begin
         if (dr) begin
            if (mq >= m - 1) begin nxt = 0; wrap = 1; end
            else nxt = mq + 1;
         end else begin
            if (mq == 0 || mq >= m) begin nxt = m - 1; wrap = 1; end
            else nxt = mq - 1;
         end
      end
      if (ld) begin
         nxt  = lv;
         wrap = 0;
      end
      #1;
      check("t_out", bif.t_out, (mq ^ nxt) & MASK);
      @(posedge clk);
      #1;
      acc   = st && !m_run && !m_cool;
      ended = 0;
      if (m_run) begin
         if (ab) ended = 1;
         else begin
            m_steps++;
            if (m_len != 0 && m_steps == m_len) ended = 1;
         end
      end
      m_cool = ended;
      if (ended) m_run = 0;
      if (acc) begin
         m_run   = 1;
         m_steps = 0;
         m_len   = rl;
      end
      mq = nxt;
      check("q",    bif.q,    mq);
      check("qbar", bif.qbar, (~mq) & MASK);
      check("busy", bif.busy, m_run);
      check("done", bif.done, ended);
      check("tc",   bif.tc,   wrap);
      @(negedge clk);
   endtask

   task automatic idle(input int n, input int md);
      for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, md, 0, 0);
   endtask

   initial begin
      rst          = 1'b1;
      bif.start    = 1'b0;
      bif.abort    = 1'b0;
      bif.dir      = 1'b1;
      bif.load     = 1'b0;
      bif.modulus  = '0;
      bif.run_len  = '0;
      bif.load_val = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_q",     bif.q,     0);
      check("rst_qbar",  bif.qbar,  MASK);
      check("rst_busy",  bif.busy,  0);
      check("rst_done",  bif.done,  0);
      check("rst_tc",    bif.tc,    0);
      check("rst_t_out", bif.t_out, 0);
      @(negedge clk);

      // Reset in the middle of a run
      cyc(1, 0, 1, 0, 0, 10, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 10, 0);
      #2 rst = 1'b1;
      #1;
      check("midrst_q",    bif.q,    0);
      check("midrst_qbar", bif.qbar, 4'hF);
      check("midrst_busy", bif.busy, 0);
      check("midrst_done", bif.done, 0);
      @(posedge clk);
      #1;
      check("midrst_done_after", bif.done, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Up wrap with modulus 5
      cyc(1, 0, 1, 0, 5, 7, 0);
      for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0, 5, 7, 0);
      check("upwrap_final", bif.q, 2);

      // Down wrap with modulus 0
      cyc(0, 0, 0, 1, 0, 2, 0);
      cyc(1, 0, 0, 0, 0, 2, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 2, 0);
      check("down_final", bif.q, 14);

      // Load in the middle of a run
      cyc(0, 0, 1, 1, 8, 5, 0);
      cyc(1, 0, 1, 0, 8, 5, 0);
      cyc(0, 0, 1, 0, 8, 5, 0);
      cyc(0, 0, 1, 1, 8, 5, 6);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 8, 5, 0);
      check("midload_final", bif.q, 1);

      // Loaded value beyond the modulus
      cyc(0, 0, 1, 1, 10, 1, 12);
      cyc(1, 0, 1, 0, 10, 1, 0);
      idle(2, 10);
      check("oor_up", bif.q, 0);
      cyc(0, 0, 0, 1, 10, 1, 12);
      cyc(1, 0, 0, 0, 10, 1, 0);
      for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 10, 1, 0);
      check("oor_down", bif.q, 9);

      // Free run, a start while busy, then abort
      cyc(0, 0, 1, 1, 0, 0, 0);
      cyc(1, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) cyc(i == 5, 0, 1, 0, 0, (i == 5) ? 3 : 0, 0);
      cyc(0, 1, 1, 0, 0, 0, 0);
      check("free_steps", bif.q, 4);
      idle(2, 0);

      // Abort in idle is ignored; abort with load in a run keeps the load
      cyc(0, 1, 1, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 7, 0, 0);
      cyc(0, 0, 1, 0, 7, 0, 0);
      cyc(0, 1, 1, 1, 7, 0, 3);
      idle(2, 7);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0), int'($urandom_range(0, MASK)),
             int'($urandom_range(0, 6)), int'($urandom_range(0, MASK)));
      end

`ifdef TFF_SEQ_QBAR_CHK_EN
      begin
         logic [W-1:0] bad;
         check("err_clean", bif.err, 0);
         bad = ~bif.q ^ 4'b0010;
         force bif.qbar = bad;
         @(posedge clk);
         #1;
         release bif.qbar;
         for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("err_sticky", bif.err, 1);
         end
         @(negedge clk);
         rst = 1'b1;
         #1;
         check("err_rst", bif.err, 0);
         @(negedge clk);
         rst = 1'b0;
         model_reset();
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
